// File: rtl/xbar_host_arb_if.sv
// Host/device bundle for the two-host crossbar port arbiter.
// Host n occupies slice n of each packed per-host field.
interface xbar_host_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]        h_req_i;
  logic [2*AW-1:0]   h_addr_i;
  logic [1:0]        h_we_i;
  logic [2*DW-1:0]   h_wdata_i;
  logic [2*DW/8-1:0] h_be_i;
  logic [1:0]        h_gnt_o;
  logic [1:0]        h_rvalid_o;
  logic [DW-1:0]     h_rdata_o;
  logic              h_err_o;

  logic              d_req_o;
  logic [AW-1:0]     d_addr_o;
  logic              d_we_o;
  logic [DW-1:0]     d_wdata_o;
  logic [DW/8-1:0]   d_be_o;
  logic              d_gnt_i;
  logic              d_rvalid_i;
  logic [DW-1:0]     d_rdata_i;
  logic              d_err_i;

  // The arbiter itself.
  modport slave (
    input  h_req_i, h_addr_i, h_we_i, h_wdata_i, h_be_i,
    output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    output d_req_o, d_addr_o, d_we_o, d_wdata_o, d_be_o,
    input  d_gnt_i, d_rvalid_i, d_rdata_i, d_err_i
  );

  // The surrounding hosts and device.
  modport master (
    output h_req_i, h_addr_i, h_we_i, h_wdata_i, h_be_i,
    input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    input  d_req_o, d_addr_o, d_we_o, d_wdata_o, d_be_o,
    output d_gnt_i, d_rvalid_i, d_rdata_i, d_err_i
  );
endinterface

// File: rtl/xbar_host_arb.sv
// Round-robin arbiter sharing one crossbar device port between two hosts,
// with an in-order host-ID FIFO routing responses back to their requester.
module xbar_host_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  xbar_host_arb_if.slave               bus,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         unexp_rsp_o
);
  localparam int CW = $clog2(MAX_OUT+1);
  localparam int PW = $clog2(MAX_OUT);

  // ARB_HOLD: a request was presented but not granted, so the selection is frozen.
  typedef enum logic {ARB_OPEN, ARB_HOLD} arb_state_t;

  arb_state_t      state_reg, state_next;
  logic            lock_host_reg, lock_host_next;
  logic            prio_reg, prio_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            unexp_reg, unexp_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic            fifo_mem [MAX_OUT];

  logic [AW-1:0]   addr_arr  [2];
  logic [DW-1:0]   wdata_arr [2];
  logic [DW/8-1:0] be_arr    [2];
  logic [1:0]      gnt_vec;
  logic [1:0]      rvalid_vec;

  logic            sel;
  logic            d_req;
  logic            accept;
  logic            rsp_ok;
  logic            rsp_unexp;
  logic            head;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_host
      assign addr_arr[gi]   = bus.h_addr_i[gi*AW +: AW];
      assign wdata_arr[gi]  = bus.h_wdata_i[gi*DW +: DW];
      assign be_arr[gi]     = bus.h_be_i[gi*(DW/8) +: DW/8];
      assign gnt_vec[gi]    = accept && (sel == 1'(gi));
      assign rvalid_vec[gi] = rsp_ok && (head == 1'(gi));
    end
  endgenerate

  always_comb begin
    sel = prio_reg;
    if (state_reg == ARB_HOLD)     sel = lock_host_reg;
    else if (bus.h_req_i == 2'b01) sel = 1'b0;
    else if (bus.h_req_i == 2'b10) sel = 1'b1;
  end

  assign head      = fifo_mem[rd_ptr_reg];
  assign d_req     = !rst_i && bus.h_req_i[sel] && (cnt_reg < CW'(MAX_OUT));
  assign accept    = d_req && bus.d_gnt_i;
  assign rsp_ok    = !rst_i && bus.d_rvalid_i && (cnt_reg != '0);
  assign rsp_unexp = !rst_i && bus.d_rvalid_i && (cnt_reg == '0);

  assign bus.d_req_o    = d_req;
  assign bus.d_addr_o   = d_req ? addr_arr[sel] : '0;
  assign bus.d_we_o     = d_req && bus.h_we_i[sel];
  assign bus.d_wdata_o  = d_req ? wdata_arr[sel] : '0;
  assign bus.d_be_o     = d_req ? be_arr[sel] : '0;
  assign bus.h_gnt_o    = gnt_vec;
  assign bus.h_rvalid_o = rvalid_vec;
  assign bus.h_rdata_o  = (!rst_i && bus.d_rvalid_i) ? bus.d_rdata_i : '0;
  assign bus.h_err_o    = !rst_i && bus.d_rvalid_i && bus.d_err_i;
  assign outstanding_o  = cnt_reg;
  assign unexp_rsp_o    = unexp_reg;

  always_comb begin
    state_next     = ARB_OPEN;
    lock_host_next = lock_host_reg;
    prio_next      = prio_reg;
    cnt_next       = cnt_reg;
    unexp_next     = unexp_reg | rsp_unexp;
    // A dropped request while held falls through to ARB_OPEN.
    if (d_req && !bus.d_gnt_i) begin
      state_next     = ARB_HOLD;
      lock_host_next = sel;
    end
    if (accept) prio_next = ~sel;
    if (accept && !rsp_ok)      cnt_next = cnt_reg + CW'(1);
    else if (!accept && rsp_ok) cnt_next = cnt_reg - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ARB_OPEN;
      lock_host_reg <= 1'b0;
      prio_reg      <= 1'b0;
      cnt_reg       <= '0;
      unexp_reg     <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      lock_host_reg <= lock_host_next;
      prio_reg      <= prio_next;
      cnt_reg       <= cnt_next;
      unexp_reg     <= unexp_next;
      if (accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rsp_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Host-ID storage needs no reset: entries are only read while cnt > 0.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr_reg] <= sel;
  end
endmodule

// File: tb/tb_xbar_host_arb.sv
// Bench for xbar_host_arb: directed scenarios then random traffic,
// all checked each cycle against a queue-based model of the arbiter.
module tb_xbar_host_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_OUT = 4;
  localparam int CW = $clog2(MAX_OUT+1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [CW-1:0] outstanding_o;
  logic          unexp_rsp_o;

  xbar_host_arb_if #(.AW(AW), .DW(DW)) bus();

  xbar_host_arb #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .outstanding_o (outstanding_o),
    .unexp_rsp_o   (unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int         total = 0;
  int         bad = 0;
  int         m_q[$];
  bit         m_prio;
  bit         m_held;
  bit         m_held_host;
  bit         m_unexp;
  logic [1:0] m_last_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_host(input int h, input bit req, input logic [AW-1:0] addr,
                            input bit we, input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
    bus.h_req_i[h]                   = req;
    bus.h_addr_i[h*AW +: AW]         = addr;
    bus.h_we_i[h]                    = we;
    bus.h_wdata_i[h*DW +: DW]        = wd;
    bus.h_be_i[h*(DW/8) +: (DW/8)]   = be;
  endtask

  task automatic rand_host(input int h);
    drive_host(h, 1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom, (DW/8)'($urandom_range(1, 15)));
  endtask

  task automatic drop_host(input int h);
    drive_host(h, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic dev(input bit gnt, input bit rv, input logic [DW-1:0] rd, input bit er);
    bus.d_gnt_i    = gnt;
    bus.d_rvalid_i = rv;
    bus.d_rdata_i  = rd;
    bus.d_err_i    = er;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances model, waits a cycle.
  task automatic step();
    logic [1:0]      req;
    int              sel;
    bit              dreq;
    bit              acc;
    logic [AW-1:0]   e_addr;
    logic            e_we;
    logic [DW-1:0]   e_wd;
    logic [DW/8-1:0] e_be;
    logic [1:0]      e_gnt;
    logic [1:0]      e_rv;
    logic [DW-1:0]   e_rd;
    logic            e_err;
    int              e_out;
    bit              e_unexp;
    #1;
    req = bus.h_req_i;
    sel = 0; dreq = 0; acc = 0;
    e_addr = '0; e_we = 1'b0; e_wd = '0; e_be = '0;
    e_gnt = '0; e_rv = '0; e_rd = '0; e_err = 1'b0;
    if (rst_i) begin
      m_q.delete();
      m_prio = 0; m_held = 0; m_held_host = 0; m_unexp = 0;
    end
    e_out = m_q.size();
    e_unexp = m_unexp;
    if (!rst_i) begin
      if (m_held)            sel = int'(m_held_host);
      else if (req == 2'b01) sel = 0;
      else if (req == 2'b10) sel = 1;
      else                   sel = int'(m_prio);
      dreq = req[sel] && (m_q.size() < MAX_OUT);
      if (dreq) begin
        e_addr = bus.h_addr_i[sel*AW +: AW];
        e_we   = bus.h_we_i[sel];
        e_wd   = bus.h_wdata_i[sel*DW +: DW];
        e_be   = bus.h_be_i[sel*(DW/8) +: (DW/8)];
      end
      acc = dreq && bus.d_gnt_i;
      if (acc) e_gnt = 2'(1 << sel);
      if (bus.d_rvalid_i) begin
        e_rd  = bus.d_rdata_i;
        e_err = bus.d_err_i;
        if (m_q.size() > 0) e_rv = 2'(1 << m_q[0]);
      end
    end
    check("d_req",    64'(bus.d_req_o),    64'(dreq));
    check("d_addr",   64'(bus.d_addr_o),   64'(e_addr));
    check("d_we",     64'(bus.d_we_o),     64'(e_we));
    check("d_wdata",  64'(bus.d_wdata_o),  64'(e_wd));
    check("d_be",     64'(bus.d_be_o),     64'(e_be));
    check("h_gnt",    64'(bus.h_gnt_o),    64'(e_gnt));
    check("h_rvalid", 64'(bus.h_rvalid_o), 64'(e_rv));
    check("h_rdata",  64'(bus.h_rdata_o),  64'(e_rd));
    check("h_err",    64'(bus.h_err_o),    64'(e_err));
    check("outstand", 64'(outstanding_o),  64'(e_out));
    check("unexp",    64'(unexp_rsp_o),    64'(e_unexp));
    if (e_gnt != 0)
      $display("txn req  host=%0d addr=%08h we=%0d out_before=%0d", sel, e_addr, e_we, e_out);
    if (e_rv != 0)
      $display("txn rsp  host=%0d data=%08h err=%0d", m_q[0], e_rd, e_err);
    else if (!rst_i && bus.d_rvalid_i)
      $display("txn rsp  dropped (nothing outstanding) data=%08h", e_rd);
    if (!rst_i) begin
      if (bus.d_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_unexp = 1;
      end
      if (acc) begin
        m_q.push_back(sel);
        m_prio = (sel == 0);
        m_held = 0;
      end else if (dreq) begin
        m_held = 1;
        m_held_host = sel[0];
      end else begin
        m_held = 0;
      end
    end
    m_last_gnt = e_gnt;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rand_host(0);
    rand_host(1);
    dev(1'b1, 1'b1, $urandom, 1'b1);
    step();
    step();
    drop_host(0);
    drop_host(1);
    dev(1'b0, 1'b0, '0, 1'b0);
    rst_i = 1'b0;
  endtask

  logic [AW-1:0] a0;

  initial begin
    bus.h_req_i = '0; bus.h_addr_i = '0; bus.h_we_i = '0; bus.h_wdata_i = '0; bus.h_be_i = '0;
    dev(1'b0, 1'b0, '0, 1'b0);
    m_last_gnt = '0;
    @(negedge clk_i);
    do_reset();

    // T1: single request from host 0, granted at once
    drive_host(0, 1'b1, 32'h4008_0004, 1'b0, 32'h1111_2222, 4'hf);
    dev(1'b1, 1'b0, '0, 1'b0);
    #1;
    check("t1_gnt",  64'(bus.h_gnt_o),  64'(2'b01));
    check("t1_addr", 64'(bus.d_addr_o), 64'(32'h4008_0004));
    step();
    drop_host(0);
    dev(1'b0, 1'b0, '0, 1'b0);
    #1;
    check("t1_cnt", 64'(outstanding_o), 64'd1);
    step();

    // T2: both hosts hold requests, grants alternate from host 0
    do_reset();
    rand_host(0);
    rand_host(1);
    dev(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_alt", 64'(bus.h_gnt_o), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      step();
      rand_host(i % 2);
    end

    // T4: full at MAX_OUT, then one response frees a slot
    #1;
    check("t4_full_req", 64'(bus.d_req_o), 64'd0);
    check("t4_full_cnt", 64'(outstanding_o), 64'(MAX_OUT));
    step();
    dev(1'b1, 1'b1, 32'hdead_0001, 1'b0);
    #1;
    check("t4_full_req2", 64'(bus.d_req_o), 64'd0);
    step();
    dev(1'b1, 1'b0, '0, 1'b0);
    #1;
    check("t4_cnt3",   64'(outstanding_o), 64'(MAX_OUT - 1));
    check("t4_accept", 64'(bus.h_gnt_o),   64'(2'b01));
    step();
    drop_host(0);
    drop_host(1);
    dev(1'b0, 1'b0, '0, 1'b0);
    step();

    // T3: host 1 has priority, yet host 0 stays locked while stalled
    do_reset();
    rand_host(0);
    dev(1'b1, 1'b0, '0, 1'b0);
    step();
    a0 = 32'h0000_a000;
    drive_host(0, 1'b1, a0, 1'b1, 32'h5555_aaaa, 4'h3);
    dev(1'b0, 1'b0, '0, 1'b0);
    step();
    rand_host(1);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_hold_addr", 64'(bus.d_addr_o), 64'(a0));
      check("t3_hold_gnt",  64'(bus.h_gnt_o),  64'd0);
      step();
    end
    dev(1'b1, 1'b0, '0, 1'b0);
    #1;
    check("t3_gnt0", 64'(bus.h_gnt_o), 64'(2'b01));
    step();
    drop_host(0);
    #1;
    check("t3_gnt1", 64'(bus.h_gnt_o), 64'(2'b10));
    step();
    drop_host(1);
    dev(1'b0, 1'b0, '0, 1'b0);
    step();

    // T5: responses route back in grant order
    do_reset();
    dev(1'b1, 1'b0, '0, 1'b0);
    rand_host(0); step(); drop_host(0);
    rand_host(1); step(); drop_host(1);
    rand_host(0); step(); drop_host(0);
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] d;
      d = 32'hc0de_0a00 + DW'(i);
      dev(1'b0, 1'b1, d, 1'b0);
      #1;
      check("t5_rvalid", 64'(bus.h_rvalid_o), (i == 1) ? 64'(2'b10) : 64'(2'b01));
      check("t5_rdata",  64'(bus.h_rdata_o),  64'(d));
      step();
    end
    dev(1'b0, 1'b0, '0, 1'b0);
    step();

    // T6: response with nothing outstanding is dropped and sticks until reset
    do_reset();
    dev(1'b0, 1'b1, 32'hbad0_bad0, 1'b1);
    #1;
    check("t6_rvalid", 64'(bus.h_rvalid_o), 64'd0);
    step();
    dev(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_sticky", 64'(unexp_rsp_o), 64'd1);
      step();
    end
    rst_i = 1'b1;
    #1;
    check("t6_clear", 64'(unexp_rsp_o), 64'd0);
    step();

    // Random traffic honouring the host hold rules and device latency
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int h = 0; h < 2; h++) begin
        if (bus.h_req_i[h]) begin
          if (m_last_gnt[h]) begin
            if ($urandom_range(0, 1) == 1) rand_host(h);
            else drop_host(h);
          end else if ($urandom_range(0, 19) == 0) begin
            drop_host(h);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rand_host(h);
        end
      end
      dev($urandom_range(0, 3) != 0,
          (m_q.size() > 0) && ($urandom_range(0, 1) == 1),
          $urandom, 1'($urandom_range(0, 7) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
